// File: rtl/pc_fetch_sequencer.sv
// Instruction-fetch front end: holds the PC, fetches over req/ack, hands off to decode.
// Optional MISALIGN_TRAP_EN: misaligned redirects halt fetch and raise a sticky error.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        misalign_err_o
);

  typedef enum logic [1:0] {StStart, StFetch, StHold, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        squash_q, squash_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] bt_in;
  logic        load_en;
  logic [31:0] load_tgt;

`ifdef MISALIGN_TRAP_EN
  logic err_q, err_d;
  assign bt_in = branch_target_i;
`else
  assign bt_in = branch_target_i & ~32'h3;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= StStart;
      pc_q          <= RESET_PC;
      squash_q      <= 1'b0;
      pend_target_q <= 32'h0;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      squash_q      <= squash_d;
      pend_target_q <= pend_target_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    squash_d      = squash_q;
    pend_target_d = pend_target_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    load_en       = 1'b0;
    load_tgt      = bt_in;
`ifdef MISALIGN_TRAP_EN
    err_d         = err_q;
`endif

    unique case (state_q)
      StStart: state_d = StFetch;
      StFetch: begin
        if (imem_ack_i) begin
          if (branch_taken_i || squash_q) begin
            // Outstanding data is stale; a same-cycle redirect beats the pending one.
            squash_d = 1'b0;
            load_en  = 1'b1;
            load_tgt = branch_taken_i ? bt_in : pend_target_q;
          end else begin
            instr_d    = imem_rdata_i;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
            state_d    = StHold;
          end
        end else if (branch_taken_i) begin
          squash_d      = 1'b1;
          pend_target_d = bt_in;
        end
      end
      StHold: begin
        if (branch_taken_i) begin
          load_en  = 1'b1;
          load_tgt = bt_in;
        end else if (instr_ready_i) begin
          state_d = StFetch;
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StStart;
    endcase

    if (load_en) begin
`ifdef MISALIGN_TRAP_EN
      if (load_tgt[1:0] != 2'b00) begin
        err_d   = 1'b1;
        state_d = StHalt;
      end else begin
        pc_d    = load_tgt;
        state_d = StFetch;
      end
`else
      pc_d    = load_tgt;
      state_d = StFetch;
`endif
    end
  end

  assign imem_req_o    = (state_q == StFetch);
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = (state_q == StHold);
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign_err_o = err_q;
`else
  assign misalign_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer (RESET_PC = 0x100); honours MISALIGN_TRAP_EN.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign_err;
  logic        auto_ack;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign imem_ack   = auto_ack & imem_req;
  assign imem_rdata = word_at(imem_addr);

  pc_fetch_sequencer #(.RESET_PC(32'h0000_0100)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .branch_taken_i (branch_taken),
    .branch_target_i(branch_target),
    .imem_req_o     (imem_req),
    .imem_addr_o    (imem_addr),
    .imem_ack_i     (imem_ack),
    .imem_rdata_i   (imem_rdata),
    .instr_valid_o  (instr_valid),
    .instr_ready_i  (instr_ready),
    .instr_o        (instr),
    .instr_pc_o     (instr_pc),
    .misalign_err_o (misalign_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    instr_ready = 1'b0; auto_ack = 1'b0;
    step(); step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL reset_addr got %h exp 00000100", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr got %h/%h exp 0/0", instr, instr_pc); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", misalign_err); end
  endtask

  task automatic test_stream();
    logic [31:0] a;
    rst_n = 1'b1; auto_ack = 1'b1; instr_ready = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL first_req got %b/%h exp 1/00000100", imem_req, imem_addr); end
    for (int k = 0; k < 3; k++) begin
      a = 32'h100 + 32'(4 * k);
      step();
      checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL stream_valid got %b/%b exp 1/0", instr_valid, imem_req); end
      checks++; if (instr_pc !== a) begin errors++; $display("FAIL stream_pc got %h exp %h", instr_pc, a); end
      checks++; if (instr !== word_at(a)) begin errors++; $display("FAIL stream_instr got %h exp %h", instr, word_at(a)); end
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== a + 32'd4) begin errors++; $display("FAIL stream_addr got %b/%h exp 1/%h", imem_req, imem_addr, a + 32'd4); end
    end
  endtask

  task automatic test_stall();
    instr_ready = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL stall_hs got %b/%b exp 1/0", instr_valid, imem_req); end
      checks++; if (instr_pc !== 32'h10C || instr !== word_at(32'h10C)) begin errors++; $display("FAIL stall_data got %h/%h exp 0000010c/%h", instr_pc, instr, word_at(32'h10C)); end
      checks++; if (imem_addr !== 32'h110) begin errors++; $display("FAIL stall_pc got %h exp 00000110", imem_addr); end
    end
    instr_ready = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h110) begin errors++; $display("FAIL stall_resume got %b/%h exp 1/00000110", imem_req, imem_addr); end
  endtask

  task automatic test_fetch_redirect();
    auto_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h200;
    step();
    branch_taken = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h110) begin errors++; $display("FAIL squash_hold got %b/%h exp 1/00000110", imem_req, imem_addr); end
      step();
    end
    auto_ack = 1'b1;
    step();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL squash_discard got %b exp 0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL squash_target got %b/%h exp 1/00000200", imem_req, imem_addr); end
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin errors++; $display("FAIL squash_next got %b/%h exp 1/00000200", instr_valid, instr_pc); end
  endtask

  task automatic test_hold_redirect();
    branch_taken = 1'b1; branch_target = 32'h300; instr_ready = 1'b1;
    step();
    branch_taken = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL hold_redir got %b/%b/%h exp 0/1/00000300", instr_valid, imem_req, imem_addr); end
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h300 || instr !== word_at(32'h300)) begin errors++; $display("FAIL hold_redir_fetch got %b/%h/%h exp 1/00000300/%h", instr_valid, instr_pc, instr, word_at(32'h300)); end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_start got %h exp fffffffc", imem_addr); end
    step();
    checks++; if (instr_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h/%h exp fffffffc/00000000", instr_pc, imem_addr); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_fetch got %b/%h exp 1/00000000", imem_req, imem_addr); end
  endtask

  task automatic test_misalign();
    branch_taken = 1'b1; branch_target = 32'h202;
    step();
    branch_taken = 1'b0;
`ifdef MISALIGN_TRAP_EN
    for (int k = 0; k < 5; k++) begin
      checks++; if (misalign_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL misalign_halt got %b/%b/%b exp 1/0/0", misalign_err, imem_req, instr_valid); end
      step();
    end
`else
    checks++; if (misalign_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL misalign_mask got %b/%b/%h exp 0/1/00000200", misalign_err, imem_req, imem_addr); end
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin errors++; $display("FAIL misalign_fetch got %b/%h exp 1/00000200", instr_valid, instr_pc); end
`endif
    rst_n = 1'b0;
    step();
    checks++; if (misalign_err !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h100) begin errors++; $display("FAIL rerst got %b/%b/%h exp 0/0/00000100", misalign_err, imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_fetch_redirect();
    test_hold_redirect();
    test_wrap();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
